uart_byte_tx: RTL and testbench
===============================

// Module: uart_byte_tx
// PURPOSE
//  UART serialiser directly downstream of the RX-to-TX loop controller.
//  Accepts one byte per tx_req/tx_busy handshake and shifts it out on txd as an 8N1 frame, LSB first.
//  Optional parity and 2 stop bits are supported.
//  tx_busy feeds back to the controller so it can drop tx_req once the byte is taken.
// PARAMETERS
//  CLK_FREQ   50_000_000  system clock frequency, Hz
//  BAUD_RATE  115200      line rate, bit/s; BAUD_DIV = CLK_FREQ/BAUD_RATE (truncated), must be >= 4
//  PARITY_EN  0           1: insert parity bit after data bit 7
//  PARITY_ODD 0           parity sense when PARITY_EN=1 (0 even, 1 odd)
//  STOP_BITS  1           1 or 2 stop bits
// PORTS
//  clk       in   1  system clock, all logic on rising edge
//  rst       in   1  asynchronous, active-high reset
//  tx_req    in   1  level request; byte on tx_data is valid while high
//  tx_data   in   8  byte to send, sampled only at the accepting edge
//  tx_busy   out  1  high from the accepting edge until the end of the last stop bit
//  tx_done   out  1  one-cycle pulse at frame completion
//  txd       out  1  serial line, idles high
// BEHAVIOUR
//  Reset (async, any time incl. mid-frame): txd=1, tx_busy=0, tx_done=0, FSM=IDLE, counters=0; frame is abandoned.
//  FSM: IDLE -> START -> DATA -> [PARITY if PARITY_EN] -> STOP -> IDLE.
//  IDLE: txd=1. On an edge with tx_req=1: latch tx_data into the shift register, then go to START.
//   tx_busy=1 and txd=0 are registered at that same edge (1-cycle latency from request).
//  Each bit holds for exactly BAUD_DIV clocks; baud counter restarts at 0 on accept and at every bit boundary.
//  DATA: 8 bits, shift_reg[0] first, then shift right; bit index 0..7 with no wrap, exits after bit 7.
//  PARITY: txd = ^data XOR PARITY_ODD (even: total ones incl. parity is even).
//  STOP: txd=1 for STOP_BITS*BAUD_DIV clocks. On the last stop clock's edge: -> IDLE, tx_busy=0, tx_done=1 for 1 cycle.
//  Frame length = (1+8+PARITY_EN+STOP_BITS)*BAUD_DIV clocks from accept to tx_busy fall.
//  tx_req is ignored outside IDLE; tx_data changes while busy have no effect.
//  tx_req still high in the tx_done cycle: IDLE accepts it at the next edge, giving 1 idle clock of txd=1
//   before the next start bit (minimum inter-frame gap).
//  tx_req dropped before accept: no frame is sent. There is no cancel path other than rst.
//  Counter widths: baud counter $clog2(BAUD_DIV); bit index 3 bits.
// STRUCTURE
//  Shared defs file (uart_defs): FSM state localparams (IDLE/START/DATA/PARITY/STOP), and the BAUD_DIV computation macro/function.
//   The defs file is reused by the RX side.
//  Sub-module uart_baud_gen: counter with sync clear, emits bit_end pulse every BAUD_DIV clocks.
//  Top: FSM, shift register, parity accumulator, registered txd/tx_busy/tx_done.
// TESTING (CLK_FREQ=1_000_000, BAUD_RATE=100_000 -> BAUD_DIV=10 unless stated)
//  1. Byte 0x55, 8N1: tx_req 1 clk after reset -> txd 0,1,0,1,0,1,0,1,0,1 per 10 clks;
//     tx_busy high 100 clks; tx_done pulse at clk 100.
//  2. Loop-controller handshake model: tx_req held until tx_busy seen, bytes 0x31,0x32 -> two frames;
//     second start bit begins 1 clk after first tx_done; decoded bytes match.
//  3. PARITY_EN=1, byte 0xA5: PARITY_ODD=0 -> parity bit 0; PARITY_ODD=1 -> parity bit 1;
//     frame = 110 clks.
//  4. STOP_BITS=2, byte 0xFF -> txd low only for start bit, then high 100 clks; tx_busy high 110 clks.
//  5. rst asserted at clk 45 of a 0x00 frame -> txd=1 and tx_busy=0 immediately, no tx_done;
//     next request sends a full clean frame.
//  6. tx_data toggled and tx_req pulsed while busy -> transmitted byte unchanged, no extra frame after tx_done.

Source files
------------

// File: rtl/uart_byte_tx_pkg.sv
// ============================================================================
// uart_byte_tx_pkg : shared UART state encoding and baud divisor helper
// Rev 1.0
// ============================================================================
`default_nettype none

package uart_byte_tx_pkg;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_START  = 3'd1,
    ST_DATA   = 3'd2,
    ST_PARITY = 3'd3,
    ST_STOP   = 3'd4
  } uart_state_t;

  // Truncating divide; the RX side uses the same helper so both ends agree.
  function automatic int baud_div(input int clk_freq, input int baud_rate);
    return clk_freq / baud_rate;
  endfunction

endpackage

`default_nettype wire

// File: rtl/uart_byte_tx_baud_gen.sv
// ============================================================================
// uart_byte_tx_baud_gen : bit-period counter, bit_end on the last clock of a bit
// Rev 1.0
// ============================================================================
`default_nettype none

module uart_byte_tx_baud_gen #(
  parameter int DIV = 10
) (
  input  logic clk,
  input  logic rst,
  input  logic clear,
  output logic bit_end
);

  localparam int CNT_W = $clog2(DIV);
  localparam logic [CNT_W-1:0] LAST = CNT_W'(DIV - 1);

  logic [CNT_W-1:0] cnt;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt <= '0;
    end else if (clear || cnt == LAST) begin
      cnt <= '0;
    end else begin
      cnt <= cnt + 1'b1;
    end
  end

  assign bit_end = !clear && (cnt == LAST);

endmodule

`default_nettype wire

// File: rtl/uart_byte_tx.sv
// ============================================================================
// uart_byte_tx : UART serialiser, LSB first, optional parity and 2 stop bits
// Rev 1.0
// ============================================================================
`default_nettype none

module uart_byte_tx
  import uart_byte_tx_pkg::*;
#(
  parameter int CLK_FREQ   = 50_000_000,
  parameter int BAUD_RATE  = 115200,
  parameter int PARITY_EN  = 0,
  parameter int PARITY_ODD = 0,
  parameter int STOP_BITS  = 1
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       tx_req,
  input  logic [7:0] tx_data,
  output logic       tx_busy,
  output logic       tx_done,
  output logic       txd
);

  localparam int   BAUD_DIV  = baud_div(CLK_FREQ, BAUD_RATE);
  localparam logic PAR_INIT  = (PARITY_ODD != 0);
  localparam logic STOP_LAST = (STOP_BITS == 2);

  uart_state_t state, state_nxt;
  logic [7:0]  shift_reg, shift_nxt;
  logic [2:0]  bit_idx, bit_idx_nxt;
  logic        parity, parity_nxt;
  logic        stop_idx, stop_idx_nxt;
  logic        txd_nxt, busy_nxt, done_nxt;
  logic        bit_end;

  uart_byte_tx_baud_gen #(
    .DIV (BAUD_DIV)
  ) u_baud (
    .clk     (clk),
    .rst     (rst),
    .clear   (state == ST_IDLE),
    .bit_end (bit_end)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= ST_IDLE;
      shift_reg <= '0;
      bit_idx   <= '0;
      parity    <= 1'b0;
      stop_idx  <= 1'b0;
      txd       <= 1'b1;
      tx_busy   <= 1'b0;
      tx_done   <= 1'b0;
    end else begin
      state     <= state_nxt;
      shift_reg <= shift_nxt;
      bit_idx   <= bit_idx_nxt;
      parity    <= parity_nxt;
      stop_idx  <= stop_idx_nxt;
      txd       <= txd_nxt;
      tx_busy   <= busy_nxt;
      tx_done   <= done_nxt;
    end
  end

  // Outputs are computed one edge ahead so txd/tx_busy/tx_done come straight from flops.
  always_comb begin
    state_nxt    = state;
    shift_nxt    = shift_reg;
    bit_idx_nxt  = bit_idx;
    parity_nxt   = parity;
    stop_idx_nxt = stop_idx;
    txd_nxt      = txd;
    busy_nxt     = tx_busy;
    done_nxt     = 1'b0;

    case (state)
      ST_IDLE: begin
        txd_nxt  = 1'b1;
        busy_nxt = 1'b0;
        if (tx_req) begin
          shift_nxt    = tx_data;
          parity_nxt   = PAR_INIT;
          bit_idx_nxt  = 3'd0;
          stop_idx_nxt = 1'b0;
          txd_nxt      = 1'b0;
          busy_nxt     = 1'b1;
          state_nxt    = ST_START;
        end
      end
      ST_START: begin
        if (bit_end) begin
          txd_nxt     = shift_reg[0];
          parity_nxt  = parity ^ shift_reg[0];
          shift_nxt   = shift_reg >> 1;
          bit_idx_nxt = 3'd0;
          state_nxt   = ST_DATA;
        end
      end
      ST_DATA: begin
        if (bit_end) begin
          if (bit_idx == 3'd7) begin
            if (PARITY_EN != 0) begin
              txd_nxt   = parity;
              state_nxt = ST_PARITY;
            end else begin
              txd_nxt   = 1'b1;
              state_nxt = ST_STOP;
            end
          end else begin
            bit_idx_nxt = bit_idx + 3'd1;
            txd_nxt     = shift_reg[0];
            parity_nxt  = parity ^ shift_reg[0];
            shift_nxt   = shift_reg >> 1;
          end
        end
      end
      ST_PARITY: begin
        if (bit_end) begin
          txd_nxt   = 1'b1;
          state_nxt = ST_STOP;
        end
      end
      ST_STOP: begin
        txd_nxt = 1'b1;
        if (bit_end) begin
          if (stop_idx == STOP_LAST) begin
            busy_nxt  = 1'b0;
            done_nxt  = 1'b1;
            state_nxt = ST_IDLE;
          end else begin
            stop_idx_nxt = 1'b1;
          end
        end
      end
      default: begin
        txd_nxt   = 1'b1;
        busy_nxt  = 1'b0;
        state_nxt = ST_IDLE;
      end
    endcase
  end

endmodule

`default_nettype wire

// File: tb/tb_uart_byte_tx.sv
// ============================================================================
// tb_uart_byte_tx : four configurations of uart_byte_tx checked against a frame model
// Rev 1.0
// ============================================================================
`default_nettype none

module tb_uart_byte_tx;

  localparam int BD = 10;
  localparam int PE [4] = '{0, 1, 1, 0};
  localparam int PO [4] = '{0, 0, 1, 0};
  localparam int SB [4] = '{1, 1, 1, 2};

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       tx_req = 1'b0;
  logic [7:0] tx_data = 8'h00;
  logic [3:0] txd_v, busy_v, done_v;

  int n_checks = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

  uart_byte_tx #(.CLK_FREQ(1_000_000), .BAUD_RATE(100_000), .PARITY_EN(0), .PARITY_ODD(0), .STOP_BITS(1))
    u_8n1 (.clk(clk), .rst(rst), .tx_req(tx_req), .tx_data(tx_data),
           .tx_busy(busy_v[0]), .tx_done(done_v[0]), .txd(txd_v[0]));
  uart_byte_tx #(.CLK_FREQ(1_000_000), .BAUD_RATE(100_000), .PARITY_EN(1), .PARITY_ODD(0), .STOP_BITS(1))
    u_8e1 (.clk(clk), .rst(rst), .tx_req(tx_req), .tx_data(tx_data),
           .tx_busy(busy_v[1]), .tx_done(done_v[1]), .txd(txd_v[1]));
  uart_byte_tx #(.CLK_FREQ(1_000_000), .BAUD_RATE(100_000), .PARITY_EN(1), .PARITY_ODD(1), .STOP_BITS(1))
    u_8o1 (.clk(clk), .rst(rst), .tx_req(tx_req), .tx_data(tx_data),
           .tx_busy(busy_v[2]), .tx_done(done_v[2]), .txd(txd_v[2]));
  uart_byte_tx #(.CLK_FREQ(1_000_000), .BAUD_RATE(100_000), .PARITY_EN(0), .PARITY_ODD(0), .STOP_BITS(2))
    u_8n2 (.clk(clk), .rst(rst), .tx_req(tx_req), .tx_data(tx_data),
           .tx_busy(busy_v[3]), .tx_done(done_v[3]), .txd(txd_v[3]));

  typedef struct {
    logic [7:0] data;
    bit         disturb;
    logic       par_even;
  } vec_t;

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, got, exp);
    end
  endtask

  // Expected {txd, tx_busy, tx_done} k cycles after the accepting edge.
  function automatic logic [2:0] model(input int i, input logic [7:0] b, input int k);
    int   len;
    int   bn;
    logic l;
    len = (9 + PE[i] + SB[i]) * BD;
    bn  = k / BD;
    if (k < len) begin
      if (bn == 0)                      l = 1'b0;
      else if (bn <= 8)                 l = b[bn-1];
      else if (PE[i] != 0 && bn == 9)   l = (^b) ^ (PO[i] != 0);
      else                              l = 1'b1;
      return {l, 2'b10};
    end
    if (k == len) return 3'b101;
    return 3'b100;
  endfunction

  task automatic wait_idle(input string name);
    int n;
    n = 0;
    while (busy_v != 4'h0 && n < 300) begin
      @(negedge clk);
      n++;
    end
    if (busy_v != 4'h0) check({name, "_idle_timeout"}, {28'h0, busy_v}, 32'h0);
  endtask

  // Sends one byte to all four instances and compares every cycle against the model.
  task automatic run_frame(input logic [7:0] b, input bit disturb, output logic par_e, output logic par_o);
    int         first_bad [4];
    logic [2:0] got_s [4];
    logic [2:0] exp_s [4];
    logic [2:0] g;
    logic [2:0] e;
    tx_data = b;
    tx_req  = 1'b1;
    par_e   = 1'bx;
    par_o   = 1'bx;
    for (int i = 0; i < 4; i++) begin
      first_bad[i] = -1;
      got_s[i] = '0;
      exp_s[i] = '0;
    end
    for (int k = 0; k <= 125; k++) begin
      @(negedge clk);
      for (int i = 0; i < 4; i++) begin
        g = {txd_v[i], busy_v[i], done_v[i]};
        e = model(i, b, k);
        if (g !== e && first_bad[i] < 0) begin
          first_bad[i] = k;
          got_s[i] = g;
          exp_s[i] = e;
        end
      end
      if (k == 95) begin
        par_e = txd_v[1];
        par_o = txd_v[2];
      end
      if (k == 0) tx_req = 1'b0;
      if (disturb) begin
        if (k == 30) tx_data = ~b;
        if (k == 40) tx_req = 1'b1;
        if (k == 42) tx_req = 1'b0;
      end
    end
    for (int i = 0; i < 4; i++) begin
      n_checks++;
      if (first_bad[i] >= 0) begin
        n_fail++;
        $display("FAIL frame inst%0d byte %02h cycle %0d: got txd/busy/done %b expected %b",
                 i, b, first_bad[i], got_s[i], exp_s[i]);
      end
    end
  endtask

  vec_t vecs [6];
  logic pe, po;
  logic [9:0] fr;
  int   seen;
  logic [7:0] rb;

  initial begin
    vecs[0] = '{data: 8'h55, disturb: 1'b0, par_even: 1'b0};
    vecs[1] = '{data: 8'hA5, disturb: 1'b0, par_even: 1'b0};
    vecs[2] = '{data: 8'hFF, disturb: 1'b0, par_even: 1'b0};
    vecs[3] = '{data: 8'h80, disturb: 1'b1, par_even: 1'b1};
    vecs[4] = '{data: 8'h31, disturb: 1'b1, par_even: 1'b1};
    vecs[5] = '{data: 8'h00, disturb: 1'b0, par_even: 1'b0};

    repeat (3) @(negedge clk);
    check("reset_txd", {28'h0, txd_v}, 32'hF);
    check("reset_busy", {28'h0, busy_v}, 32'h0);
    check("reset_done", {28'h0, done_v}, 32'h0);
    rst = 1'b0;
    @(negedge clk);

    // Table: full-trace check on all configurations plus the parity bit against hand values.
    for (int v = 0; v < 6; v++) begin
      run_frame(vecs[v].data, vecs[v].disturb, pe, po);
      check($sformatf("parity_even_%02h", vecs[v].data), {31'h0, pe}, {31'h0, vecs[v].par_even});
      check($sformatf("parity_odd_%02h", vecs[v].data), {31'h0, po}, {31'h0, ~vecs[v].par_even});
    end

    // Request pulse that never crosses a rising edge: nothing may be sent.
    #1 tx_req = 1'b1;
    #2 tx_req = 1'b0;
    seen = 0;
    for (int k = 0; k < 15; k++) begin
      @(negedge clk);
      if (busy_v != 4'h0 || txd_v != 4'hF) seen++;
    end
    check("short_req_ignored", seen, 0);

    // Loop-controller handshake on the 8N1 instance: 0x31 then 0x32 back-to-back.
    tx_data = 8'h31;
    tx_req  = 1'b1;
    seen = 0;
    while (busy_v[0] !== 1'b1 && seen < 20) begin
      @(negedge clk);
      seen++;
    end
    check("hs_accept", {31'h0, busy_v[0]}, 32'h1);
    tx_req = 1'b0;
    fr = '0;
    for (int k = 0; k <= 101; k++) begin
      if (k > 0) @(negedge clk);
      if (k % BD == 5 && k < 100) fr[k/BD] = txd_v[0];
      if (k == 50) begin
        tx_data = 8'h32;
        tx_req  = 1'b1;
      end
      if (k == 100) check("hs_done_pulse", {30'h0, done_v[0], txd_v[0]}, 32'h3);
      if (k == 101) check("hs_gap_start", {30'h0, busy_v[0], txd_v[0]}, 32'h2);
    end
    tx_req = 1'b0;
    check("hs_frame1", {22'h0, fr}, {22'h0, 1'b1, 8'h31, 1'b0});
    fr = '0;
    for (int k = 1; k <= 100; k++) begin
      @(negedge clk);
      if (k % BD == 5) fr[k/BD] = txd_v[0];
    end
    check("hs_frame2", {22'h0, fr}, {22'h0, 1'b1, 8'h32, 1'b0});
    wait_idle("hs");
    repeat (3) @(negedge clk);

    // Asynchronous reset in the middle of a 0x00 frame.
    tx_data = 8'h00;
    tx_req  = 1'b1;
    for (int k = 0; k <= 45; k++) begin
      @(negedge clk);
      if (k == 0) tx_req = 1'b0;
    end
    #2 rst = 1'b1;
    #1;
    check("midrst_txd", {28'h0, txd_v}, 32'hF);
    check("midrst_busy", {28'h0, busy_v}, 32'h0);
    @(negedge clk);
    rst = 1'b0;
    seen = 0;
    for (int k = 0; k < 30; k++) begin
      @(negedge clk);
      if (done_v != 4'h0 || busy_v != 4'h0) seen++;
    end
    check("midrst_no_done", seen, 0);
    run_frame(8'h00, 1'b0, pe, po);

    // Random bytes, randomly disturbed while busy.
    for (int r = 0; r < 8; r++) begin
      rb = 8'($urandom_range(0, 255));
      run_frame(rb, 1'($urandom_range(0, 1)), pe, po);
      check($sformatf("rand_par_even_%02h", rb), {31'h0, pe}, {31'h0, ^rb});
      check($sformatf("rand_par_odd_%02h", rb), {31'h0, po}, {31'h0, ~(^rb)});
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

`default_nettype wire
